// File: rtl/line_clear_engine.sv
// Playfield owner: merges a locked tetromino into the 10x20 board, removes full rows,
// compacts the board downward and keeps a running count of cleared lines.
module line_clear_engine #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 20,
  parameter int unsigned TOT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      lock_valid,
  input  logic [9:0]                lockX1,
  input  logic [9:0]                lockX2,
  input  logic [9:0]                lockX3,
  input  logic [9:0]                lockX4,
  input  logic [9:0]                lockY1,
  input  logic [9:0]                lockY2,
  input  logic [9:0]                lockY3,
  input  logic [9:0]                lockY4,
  output logic [0:WIDTH*HEIGHT-1]   boardMemory,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                lines_cleared,
  output logic                      lock_conflict,
  output logic [TOT_W-1:0]          total_lines
);

  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam int unsigned ColW = $clog2(WIDTH);
  localparam logic [9:0] ColLim = 10'(WIDTH);
  localparam logic [9:0] RowLim = 10'(HEIGHT);
  localparam logic [RowW-1:0] LastRow = RowW'(HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StMerge, StScan, StFill, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] board_q [HEIGHT];
  logic [WIDTH-1:0] board_d [HEIGHT];
  logic [9:0]       x_q [4];
  logic [9:0]       x_d [4];
  logic [9:0]       y_q [4];
  logic [9:0]       y_d [4];
  logic [RowW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       lines_q, lines_d;
  logic             conflict_q, conflict_d;
  logic [TOT_W-1:0] total_q, total_d;

  logic             row_full;
  logic             scan_last;
  logic             fill_last;
  logic             commit;
  logic [TOT_W:0]   sat_sum;

  assign row_full  = &board_q[rd_q];
  assign scan_last = (state_q == StScan) && (rd_q == '0);
  assign fill_last = (state_q == StFill) && (wr_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (lock_valid) state_d = StMerge;
      StMerge: state_d = StScan;
      StScan:  if (scan_last) state_d = (cnt_d == '0) ? StDone : StFill;
      StFill:  if (fill_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    board_d    = board_q;
    x_d        = x_q;
    y_d        = y_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    lines_d    = lines_q;
    conflict_d = conflict_q;
    total_d    = total_q;
    commit     = 1'b0;
    sat_sum    = '0;
    if (clr) begin
      for (int r = 0; r < HEIGHT; r++) board_d[r] = '0;
      lines_d    = '0;
      conflict_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lock_valid) begin
            x_d[0] = lockX1;
            x_d[1] = lockX2;
            x_d[2] = lockX3;
            x_d[3] = lockX4;
            y_d[0] = lockY1;
            y_d[1] = lockY2;
            y_d[2] = lockY3;
            y_d[3] = lockY4;
            conflict_d = 1'b0;
          end
        end
        StMerge: begin
          // Conflicts are judged against the pre-lock board only
          for (int i = 0; i < 4; i++) begin
            if (x_q[i] < ColLim && y_q[i] < RowLim) begin
              if (board_q[y_q[i][RowW-1:0]][x_q[i][ColW-1:0]]) conflict_d = 1'b1;
              board_d[y_q[i][RowW-1:0]][x_q[i][ColW-1:0]] = 1'b1;
            end
          end
          rd_d  = LastRow;
          wr_d  = LastRow;
          cnt_d = '0;
        end
        StScan: begin
          if (row_full) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            board_d[wr_q] = board_q[rd_q];
            wr_d = wr_q - RowW'(1);
          end
          rd_d = rd_q - RowW'(1);
        end
        StFill: begin
          board_d[wr_q] = '0;
          wr_d = wr_q - RowW'(1);
        end
        StDone: ;
        default: ;
      endcase
      // Results become visible on the same edge that enters StDone
      commit = (scan_last && cnt_d == '0) || fill_last;
      if (commit) begin
        lines_d = cnt_d;
        sat_sum = {1'b0, total_q} + {{(TOT_W - 2){1'b0}}, cnt_d};
        total_d = sat_sum[TOT_W] ? {TOT_W{1'b1}} : sat_sum[TOT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) board_q[r] <= '0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      lines_q    <= '0;
      conflict_q <= 1'b0;
      total_q    <= '0;
    end else begin
      board_q    <= board_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      lines_q    <= lines_d;
      conflict_q <= conflict_d;
      total_q    <= total_d;
    end
  end

  always_comb begin
    boardMemory = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        boardMemory[r*WIDTH + c] = board_q[r][c];
      end
    end
  end

  assign lines_cleared = lines_q;
  assign lock_conflict = conflict_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: a table of locks with hand-computed results,
// plus sequences for ignored lock pulses and an aborting clear.
module tb_line_clear_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         lock_valid;
  logic [9:0]   lockX1, lockX2, lockX3, lockX4;
  logic [9:0]   lockY1, lockY2, lockY3, lockY4;
  logic [0:199] boardMemory;
  logic         busy;
  logic         done;
  logic [2:0]   lines_cleared;
  logic         lock_conflict;
  logic [15:0]  total_lines;

  int n_cmp  = 0;
  int n_fail = 0;

  line_clear_engine #(.WIDTH(10), .HEIGHT(20), .TOT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .lock_valid    (lock_valid),
    .lockX1        (lockX1),
    .lockX2        (lockX2),
    .lockX3        (lockX3),
    .lockX4        (lockX4),
    .lockY1        (lockY1),
    .lockY2        (lockY2),
    .lockY3        (lockY3),
    .lockY4        (lockY4),
    .boardMemory   (boardMemory),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lock_conflict (lock_conflict),
    .total_lines   (total_lines)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][9:0] xs;
    logic [3:0][9:0] ys;
    bit              clr_first;
    int              lat;
    int              lines;
    bit              conf;
    int              total;
    int              ones;
    logic [3:0][7:0] setb;  // 255 = unused slot
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit cf, int x0, int y0, int x1, int y1, int x2, int y2,
                              int x3, int y3, int lat, int lines, bit conf, int total,
                              int ones, int b0, int b1, int b2, int b3);
    vec_t v;
    v.xs        = {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
    v.ys        = {10'(y3), 10'(y2), 10'(y1), 10'(y0)};
    v.clr_first = cf;
    v.lat       = lat;
    v.lines     = lines;
    v.conf      = conf;
    v.total     = total;
    v.ones      = ones;
    v.setb      = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first busy cycle)
  task automatic start_lock(input logic [3:0][9:0] xs, input logic [3:0][9:0] ys);
    lockX1 = xs[0]; lockX2 = xs[1]; lockX3 = xs[2]; lockX4 = xs[3];
    lockY1 = ys[0]; lockY2 = ys[1]; lockY3 = ys[2]; lockY4 = ys[3];
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
  endtask

  task automatic wait_done(input int from_cycle, output int lat);
    lat = from_cycle;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [3:0][9:0] xs;
    logic [3:0][9:0] ys;

    tbl.push_back(mk(0, 0,19, 1,19, 2,19, 3,19, 22,0,0,0, 4, 190,191,192,193));
    tbl.push_back(mk(0, 4,19, 5,19, 0,18, 1023,1023, 22,0,0,0, 7, 194,195,180,255));
    tbl.push_back(mk(0, 6,19, 7,19, 8,19, 9,19, 23,1,0,1, 1, 190,255,255,255));
    for (int c = 0; c < 9; c++)
      tbl.push_back(mk(c == 0, c,16, c,17, c,18, c,19, 22,0,0,1, 4*(c+1),
                       160+c, 170+c, 180+c, 190+c));
    tbl.push_back(mk(0, 4,15, 1023,0, 0,1023, 1023,1023, 22,0,0,1, 37, 154,255,255,255));
    tbl.push_back(mk(0, 9,16, 9,17, 9,18, 9,19, 26,4,0,5, 1, 194,255,255,255));
    tbl.push_back(mk(0, 2,2, 3,3, 1023,1023, 1023,1023, 22,0,0,5, 3, 22,33,194,255));
    tbl.push_back(mk(0, 10,5, 2,2, 4,4, 5,5, 22,0,1,5, 5, 22,33,44,55));
    tbl.push_back(mk(0, 7,7, 3,20, 1023,1023, 1023,1023, 22,0,0,5, 6, 77,194,255,255));

    rst_n = 1'b0; clr = 1'b0; lock_valid = 1'b0;
    lockX1 = '0; lockX2 = '0; lockX3 = '0; lockX4 = '0;
    lockY1 = '0; lockY2 = '0; lockY3 = '0; lockY4 = '0;
    tick();
    check("reset_board_ones", $countones(boardMemory), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_total", total_lines, 0);
    check("reset_lines", lines_cleared, 0);
    check("reset_conflict", lock_conflict, 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].clr_first) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check($sformatf("v%0d_clr_ones", i), $countones(boardMemory), 0);
        check($sformatf("v%0d_clr_busy", i), busy, 0);
        check($sformatf("v%0d_clr_lines", i), lines_cleared, 0);
        check($sformatf("v%0d_clr_total", i), total_lines, tbl[i].total);
      end
      start_lock(tbl[i].xs, tbl[i].ys);
      wait_done(1, lat);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_lines", i), lines_cleared, tbl[i].lines);
      check($sformatf("v%0d_conflict", i), lock_conflict, tbl[i].conf);
      check($sformatf("v%0d_total", i), total_lines, tbl[i].total);
      check($sformatf("v%0d_ones", i), $countones(boardMemory), tbl[i].ones);
      for (int b = 0; b < 4; b++)
        if (tbl[i].setb[b] != 8'd255)
          check($sformatf("v%0d_bit%0d", i, tbl[i].setb[b]),
                boardMemory[tbl[i].setb[b]], 1);
      tick();
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Lock pulse during a busy operation must be dropped, not queued
    xs = {10'd1023, 10'd1023, 10'd1023, 10'd9};
    ys = {10'd1023, 10'd1023, 10'd1023, 10'd0};
    start_lock(xs, ys);
    for (int c = 2; c <= 5; c++) tick();
    check("ign_busy_c5", busy, 1);
    xs = {10'd1023, 10'd1023, 10'd1023, 10'd8};
    lockX1 = xs[0]; lockX2 = xs[1]; lockX3 = xs[2]; lockX4 = xs[3];
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
    wait_done(6, lat);
    check("ign_latency", lat, 22);
    check("ign_ones", $countones(boardMemory), 7);
    check("ign_bit9", boardMemory[9], 1);
    check("ign_bit8", boardMemory[8], 0);
    count_dones(30, pulses);
    check("ign_extra_done", pulses, 0);

    // Clear mid-scan aborts the lock with no done and keeps total_lines
    xs = {10'd1023, 10'd1023, 10'd1023, 10'd0};
    ys = {10'd1023, 10'd1023, 10'd1023, 10'd0};
    start_lock(xs, ys);
    for (int c = 2; c <= 10; c++) tick();
    check("abort_busy_c10", busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ones", $countones(boardMemory), 0);
    check("abort_done_now", done, 0);
    count_dones(40, pulses);
    check("abort_no_done", pulses, 0);
    check("abort_total", total_lines, 5);
    check("abort_lines", lines_cleared, 0);
    check("abort_conflict", lock_conflict, 0);
    check("abort_ones_later", $countones(boardMemory), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
